// File: rtl/dsp_iq_stat_accum.sv
// Windowed I/Q statistics accumulator: power, signed DC sums and full-scale
// count over a programmable number of accepted samples, two-stage pipeline.
module dsp_iq_stat_accum #(
  parameter int IN_WIDTH  = 7,
  parameter int WIN_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic signed [IN_WIDTH-1:0]             i_in,
  input  logic signed [IN_WIDTH-1:0]             q_in,
  input  logic                                   valid_in,
  input  logic                                   start,
  input  logic                                   cont,
  input  logic        [WIN_WIDTH-1:0]            win_len,
  output logic                                   busy,
  output logic                                   done,
  output logic        [2*IN_WIDTH+WIN_WIDTH-1:0] pwr_sum,
  output logic signed [IN_WIDTH+WIN_WIDTH-1:0]   sum_i,
  output logic signed [IN_WIDTH+WIN_WIDTH-1:0]   sum_q,
  output logic        [WIN_WIDTH:0]              clip_cnt
);

  localparam int PW = 2*IN_WIDTH + WIN_WIDTH;
  localparam int SW = IN_WIDTH + WIN_WIDTH;
  localparam int CW = WIN_WIDTH + 1;
  localparam int QW = 2*IN_WIDTH;

  localparam logic signed [IN_WIDTH-1:0] CODE_MIN = {1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [IN_WIDTH-1:0] CODE_MAX = {1'b0, {(IN_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic is_full_scale(input logic signed [IN_WIDTH-1:0] s);
    return (s == CODE_MIN) || (s == CODE_MAX);
  endfunction

  function automatic logic [QW-1:0] square(input logic signed [IN_WIDTH-1:0] s);
    logic signed [QW-1:0] sx;
    logic signed [QW-1:0] p;
    sx = QW'(s);
    p  = sx * sx;
    return p;
  endfunction

  state_t                     state_q;
  logic                       busy_q;
  logic        [CW-1:0]       cnt_q;
  logic        [CW-1:0]       len_q;

  logic                       s1_vld_q;
  logic                       s1_last_q;
  logic                       s1_clip_q;
  logic        [QW-1:0]       s1_isq_q;
  logic        [QW-1:0]       s1_qsq_q;
  logic signed [IN_WIDTH-1:0] s1_i_q;
  logic signed [IN_WIDTH-1:0] s1_q_q;

  logic        [PW-1:0]       pwr_acc_q,  pwr_acc_d;
  logic signed [SW-1:0]       sumi_acc_q, sumi_acc_d;
  logic signed [SW-1:0]       sumq_acc_q, sumq_acc_d;
  logic        [CW-1:0]       clip_acc_q, clip_acc_d;

  logic                       done_q;
  logic        [PW-1:0]       pwr_res_q;
  logic signed [SW-1:0]       sumi_res_q;
  logic signed [SW-1:0]       sumq_res_q;
  logic        [CW-1:0]       clip_res_q;

  logic        [CW-1:0]       len_sel_s;
  logic        [CW-1:0]       cnt_inc_s;
  logic                       accept_s;
  logic                       last_s;
  logic                       clr_acc_s;
  logic        [PW-1:0]       pwr_tot_s;
  logic signed [SW-1:0]       sumi_tot_s;
  logic signed [SW-1:0]       sumq_tot_s;
  logic        [CW-1:0]       clip_tot_s;

  // Window-length decode and sample-acceptance qualifiers.
  always_comb begin
    len_sel_s = (win_len == {WIN_WIDTH{1'b0}}) ? {1'b1, {WIN_WIDTH{1'b0}}}
                                               : {1'b0, win_len};
    cnt_inc_s = cnt_q + CW'(1'b1);
    accept_s  = (state_q == ACCUM) && valid_in;
    last_s    = accept_s && (cnt_inc_s == len_q);
    clr_acc_s = ((state_q == IDLE) && start) || s1_last_q;
  end

  // Window control FSM; busy is a registered copy of "window in progress".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      len_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            len_q   <= len_sel_s;
          end
        end
        ACCUM: begin
          if (last_s) begin
            if (cont) begin
              cnt_q <= {CW{1'b0}};
              len_q <= len_sel_s;
            end else begin
              state_q <= FLUSH;
            end
          end else if (accept_s) begin
            cnt_q <= cnt_inc_s;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: per-sample squares, raw samples and full-scale flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_clip_q <= 1'b0;
      s1_isq_q  <= {QW{1'b0}};
      s1_qsq_q  <= {QW{1'b0}};
      s1_i_q    <= {IN_WIDTH{1'b0}};
      s1_q_q    <= {IN_WIDTH{1'b0}};
    end else begin
      s1_vld_q  <= accept_s;
      s1_last_q <= last_s;
      if (accept_s) begin
        s1_clip_q <= is_full_scale(i_in) || is_full_scale(q_in);
        s1_isq_q  <= square(i_in);
        s1_qsq_q  <= square(q_in);
        s1_i_q    <= i_in;
        s1_q_q    <= q_in;
      end
    end
  end

  // Stage 2: running totals including the stage-1 term; a closing window
  // clears the accumulators so the next window's first term lands on zero.
  always_comb begin
    pwr_tot_s  = pwr_acc_q + PW'(s1_isq_q) + PW'(s1_qsq_q);
    sumi_tot_s = sumi_acc_q + SW'(s1_i_q);
    sumq_tot_s = sumq_acc_q + SW'(s1_q_q);
    clip_tot_s = clip_acc_q + CW'(s1_clip_q);
    pwr_acc_d  = pwr_acc_q;
    sumi_acc_d = sumi_acc_q;
    sumq_acc_d = sumq_acc_q;
    clip_acc_d = clip_acc_q;
    if (clr_acc_s) begin
      pwr_acc_d  = {PW{1'b0}};
      sumi_acc_d = {SW{1'b0}};
      sumq_acc_d = {SW{1'b0}};
      clip_acc_d = {CW{1'b0}};
    end else if (s1_vld_q) begin
      pwr_acc_d  = pwr_tot_s;
      sumi_acc_d = sumi_tot_s;
      sumq_acc_d = sumq_tot_s;
      clip_acc_d = clip_tot_s;
    end else begin
      pwr_acc_d  = pwr_acc_q;
      sumi_acc_d = sumi_acc_q;
      sumq_acc_d = sumq_acc_q;
      clip_acc_d = clip_acc_q;
    end
  end

  // Accumulator and result registers; results only change on done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwr_acc_q  <= {PW{1'b0}};
      sumi_acc_q <= {SW{1'b0}};
      sumq_acc_q <= {SW{1'b0}};
      clip_acc_q <= {CW{1'b0}};
      done_q     <= 1'b0;
      pwr_res_q  <= {PW{1'b0}};
      sumi_res_q <= {SW{1'b0}};
      sumq_res_q <= {SW{1'b0}};
      clip_res_q <= {CW{1'b0}};
    end else begin
      pwr_acc_q  <= pwr_acc_d;
      sumi_acc_q <= sumi_acc_d;
      sumq_acc_q <= sumq_acc_d;
      clip_acc_q <= clip_acc_d;
      done_q     <= s1_last_q;
      if (s1_last_q) begin
        pwr_res_q  <= pwr_tot_s;
        sumi_res_q <= sumi_tot_s;
        sumq_res_q <= sumq_tot_s;
        clip_res_q <= clip_tot_s;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pwr_sum  = pwr_res_q;
  assign sum_i    = sumi_res_q;
  assign sum_q    = sumq_res_q;
  assign clip_cnt = clip_res_q;

endmodule

// File: tb/tb_dsp_iq_stat_accum.sv
// Directed bench for dsp_iq_stat_accum: table of single-shot windows plus
// hand-written sequences for full-length, continuous, start-ignore and reset.
module tb_dsp_iq_stat_accum;

  localparam int IW = 7;
  localparam int WW = 16;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic signed [IW-1:0]     i_in = '0;
  logic signed [IW-1:0]     q_in = '0;
  logic                     valid_in = 1'b0;
  logic                     start = 1'b0;
  logic                     cont = 1'b0;
  logic        [WW-1:0]     win_len = '0;
  logic                     busy;
  logic                     done;
  logic        [2*IW+WW-1:0] pwr_sum;
  logic signed [IW+WW-1:0]  sum_i;
  logic signed [IW+WW-1:0]  sum_q;
  logic        [WW:0]       clip_cnt;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    int len;
    int gap;
    int si[4];
    int sq[4];
    int e_pwr;
    int e_si;
    int e_sq;
    int e_clip;
  } vec_t;

  vec_t vecs[4];

  dsp_iq_stat_accum #(.IN_WIDTH(IW), .WIN_WIDTH(WW)) dut (
    .clk(clk), .resetn(resetn), .i_in(i_in), .q_in(q_in),
    .valid_in(valid_in), .start(start), .cont(cont), .win_len(win_len),
    .busy(busy), .done(done), .pwr_sum(pwr_sum), .sum_i(sum_i),
    .sum_q(sum_q), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input int exp);
    checks++;
    if (act != longint'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic start_win(input int len);
    win_len = WW'(len);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic feed(input int i, input int q, input int gap);
    valid_in = 1'b0;
    repeat (gap) step();
    i_in     = IW'(i);
    q_in     = IW'(q);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_pwr"},  longint'(pwr_sum), 0);
    check({tag, "_si"},   longint'(sum_i), 0);
    check({tag, "_sq"},   longint'(sum_q), 0);
    check({tag, "_clip"}, longint'(clip_cnt), 0);
  endtask

  // Called right after the last sample's edge: done must follow one edge later.
  task automatic finish_win(input string tag, input int e_pwr, input int e_si,
                            input int e_sq, input int e_clip);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_lat"},  longint'(n), 1);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_pwr"},  longint'(pwr_sum), e_pwr);
    check({tag, "_si"},   longint'(sum_i), e_si);
    check({tag, "_sq"},   longint'(sum_q), e_sq);
    check({tag, "_clip"}, longint'(clip_cnt), e_clip);
    step();
    check({tag, "_pulse"}, longint'(done), 0);
  endtask

  initial begin
    int d0;
    int nd;
    int drops;
    int c_pw[4];
    int c_si[4];
    int c_sq[4];

    vecs[0] = '{4, 0, '{1, 3, -64, 0}, '{2, -4, 63, 0}, 8095, -60, 61, 1};
    vecs[1] = '{4, 1, '{1, 3, -64, 0}, '{2, -4, 63, 0}, 8095, -60, 61, 1};
    vecs[2] = '{4, 2, '{63, -64, 5, -1}, '{63, 0, -5, -1}, 12086, 3, 57, 2};
    vecs[3] = '{2, 0, '{10, -20, 0, 0}, '{-10, 30, 0, 0}, 1500, -10, 20, 0};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    step();
    check_zero("reset");

    for (int k = 0; k < 4; k++) begin
      start_win(vecs[k].len);
      for (int j = 0; j < vecs[k].len; j++)
        feed(vecs[k].si[j], vecs[k].sq[j], vecs[k].gap);
      finish_win($sformatf("vec%0d", k), vecs[k].e_pwr, vecs[k].e_si,
                 vecs[k].e_sq, vecs[k].e_clip);
    end

    // win_len = 0 means a full 2^16-sample window of worst-case codes.
    start_win(0);
    d0 = done_cnt;
    i_in = IW'(-64);
    q_in = IW'(-64);
    valid_in = 1'b1;
    repeat (65536) step();
    valid_in = 1'b0;
    check("wl0_early", longint'(done_cnt - d0), 0);
    finish_win("wl0", 536870912, -4194304, -4194304, 65536);

    // Continuous mode, three back-to-back windows of 3; cont drops mid-window.
    cont = 1'b1;
    start_win(3);
    nd = 0;
    drops = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 9) begin
        i_in = IW'(c);
        q_in = IW'(c);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (c == 7) cont = 1'b0;
      step();
      if (c < 9 && busy !== 1'b1) drops++;
      if (done === 1'b1) begin
        if (nd < 4) begin
          c_pw[nd] = int'(pwr_sum);
          c_si[nd] = int'(sum_i);
          c_sq[nd] = int'(sum_q);
        end
        nd++;
      end
    end
    check("cont_drops", longint'(drops), 0);
    check("cont_ndone", longint'(nd), 3);
    check("cont_busy_end", longint'(busy), 0);
    if (nd == 3) begin
      check("cont_si0", longint'(c_si[0]), 3);
      check("cont_si1", longint'(c_si[1]), 12);
      check("cont_si2", longint'(c_si[2]), 21);
      check("cont_sq2", longint'(c_sq[2]), 21);
      check("cont_pw0", longint'(c_pw[0]), 10);
      check("cont_pw1", longint'(c_pw[1]), 100);
      check("cont_pw2", longint'(c_pw[2]), 298);
    end

    // A second start with a different length mid-window must be ignored.
    start_win(4);
    d0 = done_cnt;
    feed(1, 2, 0);
    feed(3, -4, 0);
    win_len = WW'(2);
    start = 1'b1;
    feed(-64, 63, 0);
    start = 1'b0;
    check("ign_early", longint'(done_cnt - d0), 0);
    feed(0, 0, 0);
    finish_win("ign", 8095, -60, 61, 1);

    // Reset after 2 of 4 samples aborts the window with no done.
    start_win(4);
    feed(1, 2, 0);
    feed(3, -4, 0);
    d0 = done_cnt;
    resetn = 1'b0;
    #1;
    check_zero("rstmid");
    repeat (2) step();
    resetn = 1'b1;
    i_in = IW'(5);
    q_in = IW'(5);
    valid_in = 1'b1;
    repeat (4) step();
    valid_in = 1'b0;
    check("rstmid_nodone", longint'(done_cnt - d0), 0);
    check("rstmid_pwr", longint'(pwr_sum), 0);
    start_win(4);
    feed(1, 2, 0);
    feed(3, -4, 0);
    feed(-64, 63, 0);
    feed(0, 0, 0);
    finish_win("fresh", 8095, -60, 61, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
